// File: rtl/logic64b_iter.sv
// ---------------------------------------------------------------------------
// logic64b_iter
// Multi-cycle 64-bit bitwise logic unit (AND / OR / XOR / ANDN).
// One operation is accepted with start, processed CHUNK bits per clock, and
// the full registered result appears on s together with a one-cycle done
// pulse. The result is bit-identical to the single-cycle combinational path.
//
// Parameters
//   CHUNK  bits processed per cycle (1,2,4,8,16,32,64; must divide 64)
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-high; clears all state
//   start  in   1   request; honoured only in IDLE or DONE
//   op     in   2   00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b); sampled with start
//   a      in   64  operand A; sampled with start
//   b      in   64  operand B; sampled with start
//   s      out  64  registered result; changes only on completion
//   busy   out  1   high while an operation is in progress
//   done   out  1   one-cycle pulse; s is new and valid while high
// ---------------------------------------------------------------------------
module logic64b_iter #(
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] s,
    output logic        busy,
    output logic        done
);

    localparam int N  = 64 / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [63:0]     a_l;
    logic [63:0]     b_l;
    logic [1:0]      op_l;
    logic [CW-1:0]   cnt;
    logic [63:0]     part;
    logic [63:0]     part_next;
    logic [5:0]      base;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] r_c;
    logic            accept;
    logic            last;

    // A new request is only honoured when no operation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE always lasts one cycle and may chain straight
    // into a new operation.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure decodes of the registered state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Slice of the latched operands handled this cycle, and the partial
    // result with that slice merged in.
    always_comb begin
        base = 6'(32'(cnt) * CHUNK);
        a_c  = a_l[base +: CHUNK];
        b_c  = b_l[base +: CHUNK];
        case (op_l)
            2'b00:   r_c = a_c & b_c;
            2'b01:   r_c = a_c | b_c;
            2'b10:   r_c = a_c ^ b_c;
            default: r_c = a_c & ~b_c;
        endcase
        part_next = part;
        part_next[base +: CHUNK] = r_c;
    end

    // Datapath registers. s is written only on the completing edge, so the
    // partial result is never visible outside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_l  <= '0;
            b_l  <= '0;
            op_l <= '0;
            cnt  <= '0;
            part <= '0;
            s    <= '0;
        end else if (accept) begin
            a_l  <= a;
            b_l  <= b;
            op_l <= op;
            cnt  <= '0;
            part <= '0;
        end else if (state == RUN) begin
            part <= part_next;
            if (last) begin
                s   <= part_next;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic64b_iter.sv
// ---------------------------------------------------------------------------
// tb_logic64b_iter
// Self-checking bench for logic64b_iter with CHUNK=8. Directed steps for
// reset, each operation, start-while-busy, back-to-back issue and reset
// abort, followed by random operations compared against a reference model.
// ---------------------------------------------------------------------------
module tb_logic64b_iter;

    localparam int CHUNK = 8;
    localparam int N     = 64 / CHUNK;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] s;
    logic        busy;
    logic        done;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    logic64b_iter #(.CHUNK(CHUNK)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .s     (s),
        .busy  (busy),
        .done  (done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit exceeded");
    end

    // Reference behaviour of the unit: the whole 64-bit result at once.
    function automatic logic [63:0] ref_logic(input logic [1:0] o,
                                              input logic [63:0] x,
                                              input logic [63:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return x & ~y;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_output(input string tag,
                                input logic [63:0] observed,
                                input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one operation from a negedge, scramble the inputs while it runs,
    // and return the result at the done cycle. Returns at the negedge after
    // the done cycle.
    task automatic apply_stimulus(input  logic [1:0]  o,
                                  input  logic [63:0] x,
                                  input  logic [63:0] y,
                                  output logic [63:0] res,
                                  output int          busy_cycles,
                                  output logic        got_done);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = rand64();
        b     = rand64();
        busy_cycles = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
        got_done = done;
        res      = s;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] r1;
        logic [63:0] a1;
        logic [63:0] b1;
        logic [63:0] a2;
        logic [63:0] b2;
        logic [1:0]  o2;
        logic        gd;
        int          bc;
        int          k;
        int          done_seen;
        logic [1:0]  ops3 [3];
        logic [63:0] exp3 [3];

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;

        // Reset state, checked before any clock edge.
        #1;
        check_output("reset_s", s, 64'h0);
        check_output("reset_busy", 64'(busy), 64'h0);
        check_output("reset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed AND.
        apply_stimulus(2'b00, 64'hFFFF_0000_F0F0_1234, 64'h0F0F_FFFF_FF00_FFFF, res, bc, gd);
        check_output("and_busy_cycles", 64'(bc), 64'(N));
        check_output("and_done", 64'(gd), 64'h1);
        check_output("and_s", res, 64'h0F0F_0000_F000_1234);
        check_output("and_done_low_after", 64'(done), 64'h0);
        check_output("and_s_hold", s, 64'h0F0F_0000_F000_1234);

        // Reset asserted between clock edges clears outputs at once.
        #2;
        reset = 1'b1;
        #1;
        check_output("midcycle_reset_s", s, 64'h0);
        check_output("midcycle_reset_busy", 64'(busy), 64'h0);
        check_output("midcycle_reset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // OR, XOR, ANDN on a fixed pattern.
        ops3 = '{2'b01, 2'b10, 2'b11};
        exp3 = '{64'hFFFF_AAAA_FFFF_5555, 64'h5555_AAAA_AAAA_5555, 64'h0000_AAAA_0000_5555};
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(ops3[i], 64'hAAAA_AAAA_5555_5555, 64'hFFFF_0000_FFFF_0000, res, bc, gd);
            check_output($sformatf("op%0d_s", ops3[i]), res, exp3[i]);
            check_output($sformatf("op%0d_done", ops3[i]), 64'(gd), 64'h1);
        end

        // start held high while busy with new operands, then chained in DONE.
        a1 = rand64();
        b1 = rand64();
        a2 = rand64();
        b2 = rand64();
        o2 = 2'b10;
        op    = 2'b00;
        a     = a1;
        b     = b1;
        start = 1'b1;
        @(negedge clk);
        op = o2;
        a  = a2;
        b  = b2;
        k  = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        r1 = ref_logic(2'b00, a1, b1);
        check_output("held_start_latency", 64'(k), 64'(N));
        check_output("held_start_first_s", s, r1);
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_s_no_partial", s, r1);
        k = 1;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_output("b2b_spacing", 64'(k), 64'(N + 1));
        check_output("b2b_second_s", s, ref_logic(o2, a2, b2));
        @(negedge clk);

        // Reset during the third RUN cycle aborts the operation.
        op    = 2'b01;
        a     = rand64();
        b     = rand64();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("abort_s", s, 64'h0);
        check_output("abort_busy", 64'(busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check_output("abort_no_done", 64'(done_seen), 64'h0);
        check_output("abort_s_stays_zero", s, 64'h0);
        apply_stimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, bc, gd);
        check_output("after_abort_s", res, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("after_abort_busy_cycles", 64'(bc), 64'(N));

        // Random operations: half confined to the low byte, half full width.
        for (int i = 0; i < 200; i++) begin
            logic [63:0] x;
            logic [63:0] y;
            logic [1:0]  o;
            o = 2'($urandom);
            if (i < 100) begin
                x = {56'h0, 8'($urandom)};
                y = {56'h0, 8'($urandom)};
            end else begin
                x = rand64();
                y = rand64();
            end
            apply_stimulus(o, x, y, res, bc, gd);
            check_output($sformatf("rand%0d_s", i), res, ref_logic(o, x, y));
            if (i % 20 == 0) begin
                check_output($sformatf("rand%0d_busy_cycles", i), 64'(bc), 64'(N));
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
